memory_model: RTL and testbench



---
 rtl/memory_model_if.sv | 13 +
 rtl/memory_model.sv | 32 +++
 tb/tb_memory_model.sv | 117 +++++++++++
 3 files changed

// File: rtl/memory_model_if.sv
// memory_model_if: address/enable/data bundle between the memory bench and the RAM.
interface memory_model_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    modport master (output addr, wr_en, rd_en, wdata, input rdata);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata);
endinterface

// File: rtl/memory_model.sv
// memory_model: single-port flop RAM, synchronous write, registered read-before-write.
module memory_model #(
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    memory_model_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    // Read samples mem_q, so a same-address write in the same edge returns old data.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = bus.rd_en ? mem_q[bus.addr] : rdata_q;
        if (bus.wr_en) mem_d[bus.addr] = bus.wdata;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_memory_model.sv
// tb_memory_model: directed and random checks of memory_model against an array model.
module tb_memory_model;
    logic clk;
    logic reset;
    memory_model_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();
    memory_model #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RESET_VALUE(8'hFF)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [7:0] ref_mem [4];
    logic [7:0] ref_rdata;
    int vectors = 0;
    int miscompares = 0;

    initial begin
        clk = 0;
        #7;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] exp);
        vectors++;
        assert (bus.rdata === exp) else begin
            miscompares++;
            $error("FAIL %s: rdata=%h expected %h", tag, bus.rdata, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
        ref_rdata = 8'h00;
    endtask

    task automatic step(input logic we, input logic re, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en = we;
        bus.rd_en = re;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        if (re) ref_rdata = ref_mem[a];
        if (we) ref_mem[a] = d;
        #1;
        chk("model", ref_rdata);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("async_rst", 8'h00);
        bus.wr_en = 1;
        bus.rd_en = 1;
        bus.addr  = 2'd0;
        bus.wdata = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_hold", 8'h00);
        #1;
        reset = 0;
        bus.wr_en = 0;
        bus.rd_en = 0;
    endtask

    initial begin
        reset = 1;
        bus.wr_en = 0;
        bus.rd_en = 0;
        bus.addr  = 0;
        bus.wdata = 0;
        model_reset();
        #1;
        chk("reset_rdata", 8'h00);
        #4;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'(i), 8'h00);
            chk("reset_mem", 8'hFF);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 2'(i), 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'(i), 8'h00);
            chk("wr_rd_all", 8'(8'h11 * (i + 1)));
        end
        step(1, 1, 2'd2, 8'hA5);
        chk("rbw_old", 8'h33);
        step(0, 1, 2'd2, 8'h00);
        chk("rbw_new", 8'hA5);
        step(1, 1, 2'd0, 8'hC3);
        chk("rw_diff_rd", 8'h11);
        step(0, 1, 2'd1, 8'h00);
        chk("hold_rd", 8'h22);
        for (int i = 0; i < 5; i++) begin
            step(i == 2, 0, 2'd1, 8'h5A);
            chk("hold", 8'h22);
        end
        step(0, 1, 2'd1, 8'h00);
        chk("hold_new", 8'h5A);
        step(0, 1, 2'd0, 8'h00);
        chk("rw_diff_wr", 8'hC3);
        for (int i = 0; i < 8; i++) step(1, 0, 2'($urandom_range(0, 3)), 8'($urandom));
        step(1, 0, 2'd3, 8'h77);
        step(0, 1, 2'd3, 8'h00);
        chk("pre_rst", 8'h77);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'(i), 8'h00);
            chk("post_rst", 8'hFF);
        end
        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
